// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and types for the round-robin arbitrating mux.
package rr_arb_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Channel bus for rr_arb_mux: N input channels, one registered output channel.
interface rr_arb_mux_if
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
);
  localparam int SW = $clog2(N);

  // Handshake: a word moves on a channel in the cycle where valid and ready
  // are both 1 at the rising edge; valid never waits on ready.
  logic               mode;
  logic [SW-1:0]      sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SW-1:0]      out_sel;
  logic [SW-1:0]      dbg_ptr;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel, dbg_ptr
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel, dbg_ptr
  );

endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin priority: first requester at or after ptr, wrapping modulo N.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);
  localparam int SW = $clog2(N);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = SW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-to-1 mux with fixed-select or round-robin arbitration into a one-entry output register.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [SW-1:0]    ptr;
  logic [N-1:0]     rr_grant;
  logic [SW-1:0]    rr_idx;
  logic [N-1:0]     fix_grant;
  logic [N-1:0]     grant;
  logic             can_accept;
  logic             take;
  logic [WIDTH-1:0] acc_data;
  logic [SW-1:0]    acc_idx;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SW-1:0]    out_sel_q;

  rr_arbiter #(.N(N)) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // An out-of-range sel matches no channel index and so grants nothing.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < N; i++) begin
      fix_grant[i] = (bus.sel == SW'(i)) && bus.in_valid[i];
    end
  end

  assign grant      = (bus.mode == MODE_RR) ? rr_grant : fix_grant;
  assign can_accept = !out_valid_q || bus.out_ready;
  assign bus.in_ready = grant & {N{can_accept}};
  assign take       = |bus.in_ready;

  always_comb begin
    acc_data = '0;
    acc_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        acc_data = acc_data | bus.in_data[i*WIDTH +: WIDTH];
        acc_idx  = SW'(i);
      end
    end
  end

  // Load on accept even while draining, so back-to-back words leave no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr         <= '0;
    end else begin
      if (take) begin
        out_data_q  <= acc_data;
        out_sel_q   <= acc_idx;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (take && bus.mode == MODE_RR) begin
        ptr <= (rr_idx == SW'(N-1)) ? '0 : rr_idx + 1'b1;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.dbg_ptr   = ptr;

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel.
REQ-002 Parameter N, default 4: input channel count, range 2..16.
REQ-003 Parameter SW, default $clog2(N): select/index width, derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel index used when mode=0.
REQ-008 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready, combinational.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_sel  output  SW  registered index of channel that supplied out_data.

Function
REQ-015 Output stage SHALL be a one-entry register; can_accept = !out_valid | out_ready.
REQ-016 Transfer on input i SHALL occur when in_valid[i] & in_ready[i]; at most one transfer per cycle.
REQ-017 in_ready[i] SHALL equal grant[i] & can_accept; grant one-hot or zero.
REQ-018 mode=0: grant[sel] SHALL be 1 iff in_valid[sel]; sel >= N yields no grant.
REQ-019 mode=1: grant SHALL go to first valid channel searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
REQ-020 ptr SHALL update to (granted index + 1) mod N only on a mode=1 transfer; unchanged otherwise, including mode=0 transfers.
REQ-021 Latency: data accepted in cycle t SHALL appear on out_data/out_valid/out_sel in cycle t+1.
REQ-022 out_valid & !out_ready: out_data, out_sel SHALL hold stable; all in_ready SHALL be 0.
REQ-023 Simultaneous drain and accept (out_valid & out_ready & transfer): register SHALL load new word, out_valid stays 1, no bubble.
REQ-024 Drain with no transfer: out_valid SHALL fall to 0; out_data, out_sel hold last value.
REQ-025 No valid inputs: no grant, ptr unchanged, in_ready all 0.
REQ-026 mode or sel change SHALL affect only the grant of the same cycle; no internal state besides ptr and output register.
REQ-027 in_ready SHALL NOT depend on in_data; it may depend on in_valid, mode, sel, ptr, out_valid, out_ready.

Reset
REQ-028 On rst assertion, immediately: out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-029 Reset mid-transfer SHALL discard the held word; no output after release until a new transfer.
REQ-030 First round-robin grant after reset SHALL search from channel 0.

Structure
REQ-031 Shared package rr_arb_pkg SHALL hold default WIDTH/N constants and a mode enum (MODE_FIXED=0, MODE_RR=1).
REQ-032 Round-robin priority logic SHALL be a sub-module rr_arbiter (req[N], ptr[SW] -> grant[N], grant_idx[SW]), purely combinational; ptr register lives in rr_arb_mux.

Verification
REQ-033 mode=1, in_valid=4'b1111, out_ready=1, data i = 32'hA0+i -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 32'hA0..A3,A0, no bubbles.
REQ-034 mode=1, only ch2 valid, ptr=3 -> grant ch2, out_sel=2 next cycle, ptr becomes 3.
REQ-035 mode=0, sel=1, in_valid=4'b1101 -> in_ready=0, out_valid stays 0; set in_valid[1] -> out_data=ch1 next cycle.
REQ-036 Backpressure: word 32'h1234 held, out_ready=0 for 5 cycles -> out_data stable 32'h1234, in_ready=0; release -> accepted and delivered in the same cycle (REQ-023).
REQ-037 rst asserted asynchronously mid-cycle with out_valid=1 -> out_valid, out_data, out_sel go 0 before next edge; after release, round-robin restarts at ch0.
REQ-038 Parameter sweep N=3, WIDTH=8: sel=3 in mode=0 -> no grant; round-robin wraps 2 -> 0.
